bus_sequencer: RTL and testbench

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/seq_pkg.sv | 40 ++++
 rtl/seq_strobe_dec.sv | 43 ++++
 rtl/bus_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_bus_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the bus sequencer: opcode constants, the sequencer
// state enum, the instruction word layout and a one-hot helper.
// -----------------------------------------------------------------------------
package seq_pkg;

    // Opcode field values (instr[7:6]).
    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    // S_NOP is only reached when subtract support is compiled out: an
    // opcode-10 word then retires in one cycle with no strobes.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_XFER  = 3'd1,
        S_OPA   = 3'd2,
        S_OPB   = 3'd3,
        S_WB    = 3'd4,
        S_IMM   = 3'd5,
        S_IMMWB = 3'd6,
        S_NOP   = 3'd7
    } state_t;

    // Instruction word layout; the two low bits carry no meaning.
    typedef struct packed {
        logic [1:0] op;
        logic [1:0] dst;
        logic [1:0] src;
        logic [1:0] rsvd;
    } instr_t;

    // Register index to one-hot select.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage : seq_pkg

// File: rtl/seq_strobe_dec.sv
// -----------------------------------------------------------------------------
// seq_strobe_dec
// Combinational decode of sequencer state plus latched dst/src register
// fields into the one-hot output-enable and load-strobe vectors for R0..R3.
//
// Ports
//   i_state   current sequencer state
//   i_dst     latched destination register index
//   i_src     latched source register index
//   o_reg_oe  one-hot bus output enable (R0..R3)
//   o_reg_ld  one-hot load strobe (R0..R3)
// -----------------------------------------------------------------------------
module seq_strobe_dec
    import seq_pkg::*;
(
    input  state_t     i_state,
    input  logic [1:0] i_dst,
    input  logic [1:0] i_src,
    output logic [3:0] o_reg_oe,
    output logic [3:0] o_reg_ld
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        o_reg_oe = 4'b0000;
        o_reg_ld = 4'b0000;
        case (i_state)
            S_XFER: begin
                o_reg_oe = onehot4(i_src);
                o_reg_ld = onehot4(i_dst);
            end
            // The destination is read first as ALU operand A, then the
            // source as operand B.
            S_OPA:   o_reg_oe = onehot4(i_dst);
            S_OPB:   o_reg_oe = onehot4(i_src);
            S_WB,
            S_IMMWB: o_reg_ld = onehot4(i_dst);
            default: ;
        endcase
    end

endmodule : seq_strobe_dec

// File: rtl/bus_sequencer.sv
// -----------------------------------------------------------------------------
// bus_sequencer
// Micro-sequencer for a 4-register, single-bus datapath with an add/subtract
// ALU and an immediate source. Accepts one instruction at a time over a
// valid/ready handshake and steps the bus strobes through the states needed
// to execute it. All strobes are Moore decodes of state plus the latched
// instruction fields and immediate.
//
// Instruction word: [7:6] op, [5:4] dst, [3:2] src, [1:0] ignored.
//   00 MOV  Rdst <- Rsrc           (XFER)
//   01 ADD  Rdst <- Rdst + Rsrc    (OPA, OPB, WB)
//   10 SUB  Rdst <- Rdst - Rsrc    (OPA, OPB, WB)
//   11 LDI  Rdst <- next word      (IMM, IMMWB)
//
// Configuration
//   SEQ_SUB_EN  when defined, opcode 10 executes SUB; when undefined it is
//               accepted as a one-cycle NOP that only pulses op_done.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   instr_in     instruction or LDI immediate word
//   instr_valid  instr_in is presented
//   instr_ready  sequencer accepts instr_in this cycle (IDLE, IMM)
//   reg_oe       one-hot bus output enables R0..R3
//   reg_ld       one-hot load strobes R0..R3
//   alu_a_ld     load ALU operand A from bus
//   alu_b_ld     load ALU operand B from bus
//   alu_sub      ALU mode, 1 = subtract
//   alu_oe       ALU result drives bus
//   imm_oe       immediate drives bus
//   imm          held immediate value
//   op_done      one-cycle pulse on the final cycle of each instruction
// -----------------------------------------------------------------------------
module bus_sequencer
    import seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr_in,
    input  logic       instr_valid,
    output logic       instr_ready,
    output logic [3:0] reg_oe,
    output logic [3:0] reg_ld,
    output logic       alu_a_ld,
    output logic       alu_b_ld,
    output logic       alu_sub,
    output logic       alu_oe,
    output logic       imm_oe,
    output logic [7:0] imm,
    output logic       op_done
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_dst;
    logic [1:0] r_src;
    logic       r_sub;
    logic [7:0] r_imm;

    instr_t     w_instr;
    logic       w_xfer;
    logic       w_sub_op;
    logic       w_unused_rsvd;

    assign w_instr       = instr_t'(instr_in);
    assign w_unused_rsvd = ^w_instr.rsvd;
    assign w_xfer        = instr_valid && instr_ready;

`ifdef SEQ_SUB_EN
    assign w_sub_op = (w_instr.op == OP_SUB);
`else
    assign w_sub_op = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    case (w_instr.op)
                        OP_MOV:  w_next_state = S_XFER;
                        OP_ADD:  w_next_state = S_OPA;
`ifdef SEQ_SUB_EN
                        OP_SUB:  w_next_state = S_OPA;
`else
                        OP_SUB:  w_next_state = S_NOP;
`endif
                        OP_LDI:  w_next_state = S_IMM;
                        default: w_next_state = S_IDLE;
                    endcase
                end
            end
            S_OPA:   w_next_state = S_OPB;
            S_OPB:   w_next_state = S_WB;
            S_IMM:   if (w_xfer) w_next_state = S_IMMWB;
            S_XFER,
            S_WB,
            S_IMMWB,
            S_NOP:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, latched instruction fields and immediate
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dst   <= 2'b00;
            r_src   <= 2'b00;
            r_sub   <= 1'b0;
            r_imm   <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_xfer) begin
                r_dst <= w_instr.dst;
                r_src <= w_instr.src;
                r_sub <= w_sub_op;
            end
            if (r_state == S_IMM && w_xfer) begin
                r_imm <= instr_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register strobes
    // ------------------------------------------------------------------
    seq_strobe_dec u_strobe_dec (
        .i_state  (r_state),
        .i_dst    (r_dst),
        .i_src    (r_src),
        .o_reg_oe (reg_oe),
        .o_reg_ld (reg_ld)
    );

    // ------------------------------------------------------------------
    // Remaining Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready = 1'b0;
        alu_a_ld    = 1'b0;
        alu_b_ld    = 1'b0;
        alu_sub     = 1'b0;
        alu_oe      = 1'b0;
        imm_oe      = 1'b0;
        op_done     = 1'b0;
        case (r_state)
            // Ready is masked by rst so nothing is accepted while the
            // reset is held, even though the state already reads IDLE.
            S_IDLE,
            S_IMM:   instr_ready = !rst;
            S_XFER,
            S_NOP:   op_done = 1'b1;
            S_OPA: begin
                alu_a_ld = 1'b1;
                alu_sub  = r_sub;
            end
            S_OPB: begin
                alu_b_ld = 1'b1;
                alu_sub  = r_sub;
            end
            S_WB: begin
                alu_oe   = 1'b1;
                alu_sub  = r_sub;
                op_done  = 1'b1;
            end
            S_IMMWB: begin
                imm_oe   = 1'b1;
                op_done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm = r_imm;

endmodule : bus_sequencer

// File: tb/tb_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_sequencer
// Self-checking bench for bus_sequencer. A behavioural register file / ALU
// sits on the strobes (the "datapath") and a separate arithmetic model tracks
// what R0..R3 and imm must hold after each instruction. Per-cycle strobe
// patterns are derived from the instruction semantics.
// -----------------------------------------------------------------------------
module tb_bus_sequencer;

    localparam logic [1:0] T_MOV = 2'b00;
    localparam logic [1:0] T_ADD = 2'b01;
    localparam logic [1:0] T_SUB = 2'b10;
    localparam logic [1:0] T_LDI = 2'b11;

`ifdef SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr_in = 8'h00;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] reg_oe;
    logic [3:0] reg_ld;
    logic       alu_a_ld;
    logic       alu_b_ld;
    logic       alu_sub;
    logic       alu_oe;
    logic       imm_oe;
    logic [7:0] imm;
    logic       op_done;

    int n_cmp = 0;
    int n_err = 0;

    // Datapath driven by the DUT strobes
    logic [7:0] dp_reg [4];
    logic [7:0] dp_a;
    logic [7:0] dp_b;
    logic [3:0] snap_ld  = 4'b0000;
    logic       snap_a   = 1'b0;
    logic       snap_b   = 1'b0;
    logic [7:0] snap_bus = 8'h00;

    // Architectural model
    logic [7:0] m_reg [4];
    logic [7:0] exp_imm = 8'h00;

    bus_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .reg_oe      (reg_oe),
        .reg_ld      (reg_ld),
        .alu_a_ld    (alu_a_ld),
        .alu_b_ld    (alu_b_ld),
        .alu_sub     (alu_sub),
        .alu_oe      (alu_oe),
        .imm_oe      (imm_oe),
        .imm         (imm),
        .op_done     (op_done)
    );

    always #5 clk = ~clk;

    // {ready, reg_oe, reg_ld, alu_a_ld, alu_b_ld, alu_sub, alu_oe, imm_oe, op_done}
    function automatic logic [14:0] pk(input logic rdy, input logic [3:0] oe,
                                       input logic [3:0] ld, input logic a,
                                       input logic b, input logic sub,
                                       input logic aoe, input logic ioe,
                                       input logic done);
        return {rdy, oe, ld, a, b, sub, aoe, ioe, done};
    endfunction

    function automatic logic [14:0] outs();
        return {instr_ready, reg_oe, reg_ld, alu_a_ld, alu_b_ld, alu_sub,
                alu_oe, imm_oe, op_done};
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] i);
        logic [3:0] v;
        v    = 4'b0000;
        v[i] = 1'b1;
        return v;
    endfunction

    // Sample strobes mid-cycle, check bus exclusivity, compute the bus value.
    always @(negedge clk) begin : emu_sample
        int         drivers;
        logic [7:0] bus;
        drivers = $countones(reg_oe) + int'(alu_oe) + int'(imm_oe);
        n_cmp++;
        if (drivers > 1 || !$onehot0(reg_ld)) begin
            n_err++;
            $display("FAIL bus_exclusive t=%0t: drivers=%0d reg_ld=%b, required drivers<=1 and reg_ld one-hot/zero",
                     $time, drivers, reg_ld);
        end
        bus = 'x;
        for (int i = 0; i < 4; i++) if (reg_oe[i]) bus = dp_reg[i];
        if (alu_oe) bus = alu_sub ? dp_a - dp_b : dp_a + dp_b;
        if (imm_oe) bus = imm;
        snap_ld  = reg_ld;
        snap_a   = alu_a_ld;
        snap_b   = alu_b_ld;
        snap_bus = bus;
    end

    // Apply the sampled loads on the rising edge.
    always @(posedge clk) begin : emu_load
        for (int i = 0; i < 4; i++) if (snap_ld[i]) dp_reg[i] = snap_bus;
        if (snap_a) dp_a = snap_bus;
        if (snap_b) dp_b = snap_bus;
        snap_ld = 4'b0000;
        snap_a  = 1'b0;
        snap_b  = 1'b0;
    end

    // Runs one instruction from an idle sequencer (entered #1 after a rising
    // edge) and checks every cycle plus the architectural result.
    task automatic run_instr(input logic [7:0] ins, input logic [7:0] immv,
                             input int gap, input string tag);
        logic [1:0]  op;
        logic [1:0]  d;
        logic [1:0]  s;
        logic        sub;
        logic [14:0] idle_v;
        logic [14:0] exp_q [$];
        op     = ins[7:6];
        d      = ins[5:4];
        s      = ins[3:2];
        idle_v = pk(1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        n_cmp++;
        if (outs() !== idle_v) begin
            n_err++;
            $display("FAIL %s accept_idle: got %h required %h", tag, outs(), idle_v);
        end
        instr_in    = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;

        if (op == T_LDI) begin
            instr_valid = 1'b0;
            instr_in    = 8'($urandom);
            for (int i = 0; i <= gap; i++) begin
                n_cmp++;
                if (outs() !== idle_v) begin
                    n_err++;
                    $display("FAIL %s imm_wait[%0d]: got %h required %h", tag, i, outs(), idle_v);
                end
                if (i < gap) begin
                    @(posedge clk); #1;
                end
            end
            instr_in    = immv;
            instr_valid = 1'b1;
            @(posedge clk); #1;
            exp_q.push_back(pk(1'b0, 4'b0, oh(d), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        end else if (op == T_MOV) begin
            exp_q.push_back(pk(1'b0, oh(s), oh(d), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end else if (op == T_ADD || SUB_EN) begin
            sub = (op == T_SUB);
            exp_q.push_back(pk(1'b0, oh(d), 4'b0, 1'b1, 1'b0, sub, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(pk(1'b0, oh(s), 4'b0, 1'b0, 1'b1, sub, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(pk(1'b0, 4'b0, oh(d), 1'b0, 1'b0, sub, 1'b1, 1'b0, 1'b1));
        end else begin
            exp_q.push_back(pk(1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end

        // While busy, throw junk at the handshake; it must be ignored.
        foreach (exp_q[i]) begin
            n_cmp++;
            if (outs() !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s cycle%0d: got %h required %h", tag, i, outs(), exp_q[i]);
            end
            instr_valid = 1'($urandom_range(0, 1));
            instr_in    = 8'($urandom);
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;

        case (op)
            T_MOV: m_reg[d] = m_reg[s];
            T_ADD: m_reg[d] = m_reg[d] + m_reg[s];
            T_SUB: if (SUB_EN) m_reg[d] = m_reg[d] - m_reg[s];
            default: begin
                m_reg[d] = immv;
                exp_imm  = immv;
            end
        endcase

        n_cmp++;
        if ({dp_reg[3], dp_reg[2], dp_reg[1], dp_reg[0]} !== {m_reg[3], m_reg[2], m_reg[1], m_reg[0]}) begin
            n_err++;
            $display("FAIL %s regs: got %h required %h", tag,
                     {dp_reg[3], dp_reg[2], dp_reg[1], dp_reg[0]},
                     {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
        end
        n_cmp++;
        if (imm !== exp_imm) begin
            n_err++;
            $display("FAIL %s imm: got %h required %h", tag, imm, exp_imm);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (outs() !== 15'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required %h", outs(), 15'h0);
        end
        n_cmp++;
        if (imm !== 8'h00) begin
            n_err++;
            $display("FAIL reset_imm: got %h required 00", imm);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== pk(1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL reset_release_ready: got %h required %h", outs(),
                     pk(1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ldi();
        run_instr(8'b11_10_00_00, 8'hA5, 3, "ldi_r2_a5");
        run_instr(8'b11_00_00_00, 8'($urandom), 0, "ldi_r0");
        run_instr(8'b11_01_00_11, 8'($urandom), 1, "ldi_r1");
        run_instr(8'b11_11_00_00, 8'($urandom), 2, "ldi_r3");
    endtask

    task automatic test_mov();
        run_instr(8'b00_10_01_00, 8'h00, 0, "mov_r2_r1");
        run_instr(8'b00_01_01_00, 8'h00, 0, "mov_r1_r1");
    endtask

    task automatic test_add();
        run_instr(8'b01_00_11_00, 8'h00, 0, "add_r0_r3");
        run_instr(8'b01_10_10_00, 8'h00, 0, "add_r2_r2");
    endtask

    task automatic test_sub();
        run_instr(8'b11_01_00_00, 8'h37, 0, "ldi_r1_pre_sub");
        run_instr(8'b10_01_01_00, 8'h00, 0, "sub_r1_r1");
        run_instr(8'b10_00_11_00, 8'h00, 0, "sub_r0_r3");
    endtask

    task automatic test_back_to_back();
        logic [14:0] idle_v;
        idle_v = pk(1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 150; k++) begin
            int idle_n;
            idle_n = $urandom_range(0, 2);
            for (int j = 0; j < idle_n; j++) begin
                instr_in = 8'($urandom);
                n_cmp++;
                if (outs() !== idle_v) begin
                    n_err++;
                    $display("FAIL idle_hold[%0d]: got %h required %h", k, outs(), idle_v);
                end
                @(posedge clk); #1;
            end
            run_instr(8'($urandom), 8'($urandom), $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_reset_mid_op();
        logic [14:0] zero_v;
        zero_v = 15'h0;
        instr_in    = 8'b01_10_01_00;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        n_cmp++;
        if (outs() !== pk(1'b0, 4'b0100, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL midrst_opa: got %h required %h", outs(),
                     pk(1'b0, 4'b0100, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        @(posedge clk); #1;
        n_cmp++;
        if (outs() !== pk(1'b0, 4'b0010, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL midrst_opb: got %h required %h", outs(),
                     pk(1'b0, 4'b0010, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        rst = 1'b1;
        #1;
        exp_imm = 8'h00;
        n_cmp++;
        if (outs() !== zero_v) begin
            n_err++;
            $display("FAIL midrst_immediate: got %h required %h", outs(), zero_v);
        end
        n_cmp++;
        if (imm !== exp_imm) begin
            n_err++;
            $display("FAIL midrst_imm: got %h required %h", imm, exp_imm);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (outs() !== zero_v) begin
            n_err++;
            $display("FAIL midrst_held: got %h required %h", outs(), zero_v);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        // The abandoned ADD must not have written R2.
        run_instr(8'b00_11_10_00, 8'h00, 0, "post_rst_mov");
        run_instr(8'b11_00_00_00, 8'h5C, 1, "post_rst_ldi");
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_mov();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bus_sequencer
